alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, two-stage pipelined ALU with valid/ready handshakes on both sides.
//  Widens the 4-bit, 4-op combinational ALU to WIDTH bits and 8 ops, and adds CARRY and ZERO flags.
//  Sits between the operand source (register read / test driver) and the result consumer.
//  Full throughput (1 op/cycle) when the consumer is always ready; back-pressure stalls in place.
// PARAMETERS
//  WIDTH   8  operand/result width in bits, >= 2, power of two
//  SHW     $clog2(WIDTH)  shift-amount bits taken from B[SHW-1:0]; derived, do not override
// PORTS
//  CLK        in   1      clock, all state on rising edge
//  RESET      in   1      asynchronous, active-high reset
//  IN_VALID   in   1      A/B/OP valid this cycle
//  IN_READY   out  1      block accepts A/B/OP this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  OP         in   3      operation select (see BEHAVIOUR)
//  OUT_VALID  out  1      OUT and flags valid
//  OUT_READY  in   1      consumer accepts result this cycle
//  OUT        out  WIDTH  result
//  EQUAL      out  1      A == B for this op
//  EVEN       out  1      !OUT[0]
//  ZERO       out  1      OUT == 0
//  CARRY      out  1      ADD carry-out / SUB borrow; 0 for all other ops
// BEHAVIOUR
//  Ops: 000 ADD A+B | 001 AND | 010 OR | 011 XOR | 100 SUB A-B | 101 SHL A<<B[SHW-1:0]
//       110 SHR (logical) A>>B[SHW-1:0] | 111 PASS A. OP[1:0] codes match the legacy ALU for OP[2]=0.
//  Width: ADD/SUB computed at WIDTH+1 bits; OUT = low WIDTH bits (wraps mod 2^WIDTH).
//   ADD CARRY = bit WIDTH of sum; SUB CARRY = 1 iff A < B (unsigned borrow).
//   Shift amount uses only B[SHW-1:0]; upper B bits are ignored; shifted-in bits are 0.
//  Pipeline: S1 registers A,B,OP on input handshake (IN_VALID & IN_READY);
//   S2 registers OUT and all four flags, computed from S1 contents. No combinational path A/B/OP -> OUT.
//  Latency: 2 cycles from accepted input edge to OUT_VALID=1 with no stall.
//  Stage advance: S2 loads when !S2_valid | OUT_READY; S1 loads when S1 empty or S1 moves to S2.
//   IN_READY = !S1_valid | (!S2_valid | OUT_READY)  (combinational from OUT_READY; permitted).
//  Output rule: while OUT_VALID=1 & OUT_READY=0, OUT and flags hold stable; OUT_VALID never drops
//   without a completed output handshake.
//  Simultaneous events: output handshake and new input in the same cycle both take effect; no bubble.
//  Capacity: 2 ops in flight; with OUT_READY held 0 the third IN_VALID sees IN_READY=0.
//  IN_VALID=0: no S1 load; existing contents keep draining.
//  Reset (any time, mid-operation included): S1/S2 valid=0, all data regs 0; OUT=0, OUT_VALID=0,
//   EQUAL=0, EVEN=0, ZERO=0, CARRY=0; in-flight ops discarded. IN_READY=1 immediately during reset.
//  Flags are registered alongside OUT (EVEN/ZERO not recomputed combinationally from OUT port).
// TESTING (WIDTH=8 unless noted)
//  1 Reset: assert RESET mid-stream with 2 ops in flight -> OUT_VALID=0, OUT=0, all flags 0, IN_READY=1.
//  2 Ops, OUT_READY=1: ADD 0xF0+0x20 -> OUT=0x10 CARRY=1 EVEN=1; SUB 0x03-0x05 -> OUT=0xFE CARRY=1;
//    SHL 0x81,B=0x09 -> OUT=0x02 (amount 1); SHR 0x80,3 -> 0x10; XOR 0x5A,0x5A -> 0x00 ZERO=1 EQUAL=1.
//  3 Throughput: 8 back-to-back ops, OUT_READY=1 -> first result 2 cycles after first accept,
//    then one result per cycle, in order, no bubbles.
//  4 Back-pressure: OUT_READY=0 for 5 cycles with IN_VALID=1 -> exactly 2 accepted, IN_READY=0 after,
//    OUT stable; release OUT_READY -> both drain in order, no loss/duplication.
//  5 Random OUT_READY/IN_VALID 10k ops vs reference model (all 8 ops) -> exact OUT/flag match, order kept.
//  6 WIDTH=16: ADD 0xFFFF+0x0001 -> OUT=0x0000 CARRY=1 ZERO=1; SHL 0x0001,B=0x0013 -> 0x0008.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 captures A/B/OP on an input handshake; stage 2 captures the result
//   and flags computed from stage 1. One op per cycle when the consumer is ready.
// Ports:
//   CLK, RESET               clock (rising edge), asynchronous active-high reset
//   IN_VALID / IN_READY      input handshake for A, B, OP
//   A, B [WIDTH]             operands
//   OP [3]                   000 ADD, 001 AND, 010 OR, 011 XOR,
//                            100 SUB, 101 SHL, 110 SHR (logical), 111 PASS A
//   OUT_VALID / OUT_READY    output handshake for OUT and flags
//   OUT [WIDTH]              result
//   EQUAL                    operands of this op were equal
//   EVEN                     result bit 0 is clear
//   ZERO                     result is zero
//   CARRY                    ADD carry-out, SUB borrow (A < B), else 0
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             EQUAL,
    output logic             EVEN,
    output logic             ZERO,
    output logic             CARRY
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Stage 1 operand registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    // Handshake / advance controls
    logic s2_advance_c;
    logic in_accept_c;

    // Stage 1 -> stage 2 combinational ALU
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;

    // Stage 2 frees up when empty or its result is taken this cycle; stage 1
    // can accept whenever it is empty or is moving into stage 2.
    assign s2_advance_c = !OUT_VALID || OUT_READY;
    assign IN_READY     = !s1_valid || s2_advance_c;
    assign in_accept_c  = IN_VALID && IN_READY;

    // ALU datapath; ADD/SUB run one bit wider so bit WIDTH is carry/borrow
    always_comb begin
        sum_c   = {1'b0, s1_a} + {1'b0, s1_b};
        diff_c  = {1'b0, s1_a} - {1'b0, s1_b};
        shamt_c = s1_b[SHW-1:0];
        res_c   = '0;
        carry_c = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
            end
            OP_AND:  res_c = s1_a & s1_b;
            OP_OR:   res_c = s1_a | s1_b;
            OP_XOR:  res_c = s1_a ^ s1_b;
            OP_SUB: begin
                res_c   = diff_c[WIDTH-1:0];
                carry_c = diff_c[WIDTH];
            end
            OP_SHL:  res_c = s1_a << shamt_c;
            OP_SHR:  res_c = s1_a >> shamt_c;
            OP_PASS: res_c = s1_a;
            default: res_c = '0;
        endcase
    end

    // Stage 1: valid follows IN_VALID whenever the slot is free to change
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (IN_READY) begin
                s1_valid <= IN_VALID;
            end
            if (in_accept_c) begin
                s1_a  <= A;
                s1_b  <= B;
                s1_op <= OP;
            end
        end
    end

    // Stage 2: result and flags registered together; held while stalled
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            OUT       <= '0;
            EQUAL     <= 1'b0;
            EVEN      <= 1'b0;
            ZERO      <= 1'b0;
            CARRY     <= 1'b0;
        end else if (s2_advance_c) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                OUT   <= res_c;
                EQUAL <= (s1_a == s1_b);
                EVEN  <= !res_c[0];
                ZERO  <= (res_c == '0);
                CARRY <= carry_c;
            end
        end
    end

endmodule
